// File: rtl/mu0_flag_unit.sv
// Registered N/Z/C/V status flags, sticky overflow VS and branch-condition decode for MU0.
// Optional macro FLAG_SHADOW_EN adds a 4-bit interrupt shadow of the flags (irq_save/irq_restore).
module mu0_flag_unit #(
  parameter int WIDTH        = 16,
  parameter bit CLR_ON_RESET = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] result,
  input  logic             alu_cout,
  input  logic             a_msb,
  input  logic             b_msb,
  input  logic             alu_sub,
  input  logic             flag_we,
  input  logic             flag_ld,
  input  logic [3:0]       flag_din,
  input  logic             vs_clr,
  input  logic             irq_save,
  input  logic             irq_restore,
  input  logic [3:0]       cond,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             VS,
  output logic             cond_true
);

  // No handshake: all writes are single-cycle strobes sampled on the rising edge.
  logic [3:0] flags;
  logic [3:0] alu_flags;
  logic [3:0] shadow_val;
  logic       v_calc;
  logic       restore_win;
  logic       vs_q;

  // Signed overflow: operands agree in sign (B after inversion for subtract) but result differs.
  assign v_calc    = (a_msb == (b_msb ^ alu_sub)) && (result[WIDTH-1] != a_msb);
  assign alu_flags = {result[WIDTH-1], (result == '0), alu_cout, v_calc};

`ifdef FLAG_SHADOW_EN
  logic [3:0] shadow;

  // Shadow always captures the pre-update flags, so save+restore performs a swap.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow <= 4'b0000;
    end else if (irq_save) begin
      shadow <= flags;
    end
  end

  assign restore_win = irq_restore;
  assign shadow_val  = shadow;
`else
  logic unused_irq;
  assign unused_irq  = irq_save ^ irq_restore;
  assign restore_win = 1'b0;
  assign shadow_val  = 4'b0000;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= 4'b0000;
    end else if (restore_win) begin
      flags <= shadow_val;
    end else if (flag_ld) begin
      flags <= flag_din;
    end else if (flag_we) begin
      flags <= alu_flags;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if (CLR_ON_RESET) begin
        vs_q <= 1'b0;
      end
    end else if (flag_we && !flag_ld && !restore_win && v_calc) begin
      vs_q <= 1'b1;
    end else if (vs_clr) begin
      vs_q <= 1'b0;
    end
  end

  assign {N, Z, C, V} = flags;
  assign VS           = vs_q;

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = Z;
      4'd2:    cond_true = ~Z;
      4'd3:    cond_true = N;
      4'd4:    cond_true = ~N;
      4'd5:    cond_true = C;
      4'd6:    cond_true = ~C;
      4'd7:    cond_true = V;
      4'd8:    cond_true = ~V;
      4'd9:    cond_true = (N == V);
      4'd10:   cond_true = (N != V);
      4'd11:   cond_true = ~Z & (N == V);
      4'd12:   cond_true = Z | (N != V);
      4'd13:   cond_true = C & ~Z;
      4'd14:   cond_true = ~C | Z;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: doc/mu0_flag_unit.md
Name: mu0_flag_unit

Overview:
- Parametrised, registered successor to the MU0 combinational N/Z flag generator.
- Holds a status register with N, Z, C and V flags, updated from the ALU result, plus a sticky overflow flag.
- Evaluates a 4-bit branch condition code against the stored flags for the control unit.
- Sits in the datapath between the ALU output and the sequencer. It replaces the direct Acc-driven N/Z outputs used for conditional jumps.

Parameters:
WIDTH  16  data width of ALU result/accumulator; legal range 4..64
CLR_ON_RESET  1  1: VS sticky flag cleared by reset; 0: VS only cleared by vs_clr

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
result  input  WIDTH  ALU result being written to Acc this cycle
alu_cout  input  1  ALU carry-out, or not-borrow for subtract
a_msb  input  1  MSB of ALU operand A
b_msb  input  1  MSB of ALU operand B before inversion
alu_sub  input  1  1 = ALU performing A-B
flag_we  input  1  update flags from ALU this cycle
flag_ld  input  1  load flags directly from flag_din
flag_din  input  4  {N,Z,C,V} value for flag_ld
vs_clr  input  1  clear sticky overflow
irq_save  input  1  copy flags to shadow (FLAG_SHADOW_EN only)
irq_restore  input  1  copy shadow to flags (FLAG_SHADOW_EN only)
cond  input  4  condition code to evaluate
N  output  1  negative flag (registered)
Z  output  1  zero flag (registered)
C  output  1  carry flag (registered)
V  output  1  overflow flag (registered)
VS  output  1  sticky overflow (registered)
cond_true  output  1  combinational result of cond against current N/Z/C/V

Behaviour:
- Reset: clk and reset are the only clock and reset. Reset is synchronous and active-high.
  - On a reset edge: N=Z=C=V=0, and the shadow register is set to 0.
  - VS is set to 0 when CLR_ON_RESET=1; otherwise VS holds its value.
  - Reset overrides every other input.
- Flags update on the rising edge. Outputs change one cycle after flag_we/flag_ld is sampled; there is no combinational path from result to N/Z/C/V.
- ALU update when flag_we=1:
  - N = result[WIDTH-1]
  - Z = (result == 0)
  - C = alu_cout
  - V = (a_msb == (b_msb ^ alu_sub)) && (result[WIDTH-1] != a_msb)
- flag_ld=1: {N,Z,C,V} <= flag_din. The values are not checked for consistency, so Z=1 with N=1 is legal.
- Write priority, highest first: reset, irq_restore (when the feature is enabled), flag_ld, flag_we. Lower-priority requests in the same cycle are dropped.
- Flags hold their value when no write is active.
- VS behaviour:
  - Set on any edge where flag_we=1 is the winning write and the computed V=1.
  - Cleared by vs_clr.
  - If set and clear occur in the same cycle, set wins.
  - VS is unaffected by flag_ld and irq_restore.
- cond_true decode, from the registered flags only:
  - 0 AL=1
  - 1 EQ=Z
  - 2 NE=~Z
  - 3 MI=N
  - 4 PL=~N
  - 5 CS=C
  - 6 CC=~C
  - 7 VS=V
  - 8 VC=~V
  - 9 GE=(N==V)
  - 10 LT=(N!=V)
  - 11 GT=~Z&(N==V)
  - 12 LE=Z|(N!=V)
  - 13 HI=C&~Z
  - 14 LS=~C|Z
  - 15 NV=0
- A condition evaluated in the same cycle as flag_we sees the old flags. The sequencer must allow one cycle between the update and the branch.

Optional Feature:
- Macro: FLAG_SHADOW_EN.
- When defined:
  - A 4-bit shadow register is added.
  - irq_save=1 copies the current {N,Z,C,V} into the shadow on the edge. The copy uses pre-update values, even if a flag write occurs in the same cycle.
  - irq_restore=1 loads the shadow into the flags with the highest non-reset priority.
  - If irq_save and irq_restore are both asserted, the flags take the old shadow and the shadow takes the old flags (swap).
- When undefined:
  - The ports irq_save and irq_restore remain present but are ignored.
  - No shadow storage is synthesised.

Test Plan:
1. reset=1 for 2 cycles, then flag_ld with din=4'b1111 the cycle after release -> N,Z,C,V=0 during reset; 1,1,1,1 on the following edge.
2. WIDTH=16, flag_we with result=16'h0000, alu_cout=1 -> next cycle Z=1, N=0, C=1; cond=1 gives cond_true=1, cond=13 gives 0.
3. Add 16'h7FFF+16'h0001: a_msb=0, b_msb=0, alu_sub=0, result=16'h8000, flag_we -> N=1, V=1, VS=1. Next, flag_we with result=16'h0001, V computed 0 -> V=0, VS stays 1. Then vs_clr -> VS=0.
4. flag_ld (din=4'b0001) and flag_we (result=16'h8000) in the same cycle -> flags {0,0,0,1}, and VS unchanged; vs_clr with a simultaneous overflowing flag_we -> VS=1.
5. Sweep cond 0..15 with flags N=1, V=0, Z=0, C=1 -> cond_true sequence 1,0,1,1,0,1,0,0,1,0,1,0,1,1,0,0.
6. With FLAG_SHADOW_EN defined: load flags 4'b1010, pulse irq_save, load 4'b0101, pulse irq_restore -> flags 4'b1010. Assert save and restore together -> flags and shadow swap.
